// File: rtl/wb_regfile_if.sv
// MEM/WB -> write-back/register-file bus: write-back controls and data in,
// decode-stage read ports, forwarding value and commit counter out.
interface wb_regfile_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             RegWrite_WB;
  logic             MemtoReg_WB;
  logic [XLEN-1:0]  ALUResult_WB;
  logic [XLEN-1:0]  mem_read_data_WB;
  logic [4:0]       rd_WB;
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  wb_data;
  logic             wb_we;
  logic [CNT_W-1:0] wb_count;

  modport master (
    output RegWrite_WB, MemtoReg_WB, ALUResult_WB, mem_read_data_WB,
           rd_WB, rs1_ID, rs2_ID,
    input  rs1_data, rs2_data, wb_data, wb_we, wb_count
  );

  modport slave (
    input  RegWrite_WB, MemtoReg_WB, ALUResult_WB, mem_read_data_WB,
           rd_WB, rs1_ID, rs2_ID,
    output rs1_data, rs2_data, wb_data, wb_we, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back mux, 32-entry integer register file (x0 hardwired to 0) and
// committed-write counter. Define REGFILE_BYPASS_EN for write-through reads.
module wb_regfile #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_regfile_if.slave bus
);
  logic [XLEN-1:0]  regs [1:31];
  logic [XLEN-1:0]  wb_data_int;
  logic             wb_we_int;
  logic [XLEN-1:0]  rd1;
  logic [XLEN-1:0]  rd2;
  logic [CNT_W-1:0] count_q;

  assign wb_data_int = bus.MemtoReg_WB ? bus.mem_read_data_WB : bus.ALUResult_WB;
  assign wb_we_int   = bus.RegWrite_WB && (bus.rd_WB != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wb_we_int && (bus.rd_WB == 5'(i))) regs[i] <= wb_data_int;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else if (wb_we_int) count_q <= count_q + CNT_W'(1);
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.rs1_ID == 5'(i)) rd1 = regs[i];
      if (bus.rs2_ID == 5'(i)) rd2 = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    // wb_we_int already excludes rd_WB == 0, so x0 is never bypassed
    if (wb_we_int && (bus.rs1_ID == bus.rd_WB)) rd1 = wb_data_int;
    if (wb_we_int && (bus.rs2_ID == bus.rd_WB)) rd2 = wb_data_int;
`endif
    // Reads are forced to zero for the whole reset window, bypass included
    if (!reset_n) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  assign bus.rs1_data = rd1;
  assign bus.rs2_data = rd2;
  assign bus.wb_data  = wb_data_int;
  assign bus.wb_we    = wb_we_int;
  assign bus.wb_count = count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: full-width instance plus a CNT_W=4 instance
// for counter wrap. Expected same-cycle read depends on REGFILE_BYPASS_EN.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset_n_s = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.XLEN(64), .CNT_W(32)) bus ();
  wb_regfile_if #(.XLEN(64), .CNT_W(4))  bus_s ();

  wb_regfile #(.XLEN(64), .CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  wb_regfile #(.XLEN(64), .CNT_W(4))  dut_s (.clk(clk), .reset_n(reset_n_s), .bus(bus_s));

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    bus.rs1_ID = 5'd9;
    bus.rs2_ID = 5'd31;
    #1;
    vectors++;
    if (bus.rs1_data !== 64'd0 || bus.rs2_data !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_held_read: got %h/%h expected 0/0", bus.rs1_data, bus.rs2_data);
    end
    step();
    reset_n = 1'b1;
    reset_n_s = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rs1_ID = 5'(i);
      bus.rs2_ID = 5'(31 - i);
      #1;
      vectors++;
      if (bus.rs1_data !== 64'd0 || bus.rs2_data !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_sweep[%0d]: got %h/%h expected 0/0", i, bus.rs1_data, bus.rs2_data);
      end
    end
    vectors++;
    if (bus.wb_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d expected 0", bus.wb_count);
    end
  endtask

  task automatic test_select();
    bus.RegWrite_WB = 1'b1;
    bus.MemtoReg_WB = 1'b0;
    bus.rd_WB = 5'd5;
    bus.ALUResult_WB = 64'h1111;
    bus.mem_read_data_WB = 64'h2222;
    #1;
    vectors++;
    if (bus.wb_data !== 64'h1111 || bus.wb_we !== 1'b1) begin
      miscompares++;
      $display("FAIL select_alu_mux: got %h we=%b expected 1111 we=1", bus.wb_data, bus.wb_we);
    end
    step();
    bus.RegWrite_WB = 1'b0;
    bus.rs1_ID = 5'd5;
    #1;
    vectors++;
    if (bus.rs1_data !== 64'h1111) begin
      miscompares++;
      $display("FAIL select_alu_read: got %h expected 1111", bus.rs1_data);
    end
    bus.RegWrite_WB = 1'b1;
    bus.MemtoReg_WB = 1'b1;
    #1;
    vectors++;
    if (bus.wb_data !== 64'h2222) begin
      miscompares++;
      $display("FAIL select_load_mux: got %h expected 2222", bus.wb_data);
    end
    step();
    bus.RegWrite_WB = 1'b0;
    #1;
    vectors++;
    if (bus.rs1_data !== 64'h2222) begin
      miscompares++;
      $display("FAIL select_load_read: got %h expected 2222", bus.rs1_data);
    end
    vectors++;
    if (bus.wb_count !== 32'd2) begin
      miscompares++;
      $display("FAIL select_count: got %0d expected 2", bus.wb_count);
    end
  endtask

  task automatic test_x0();
    bus.RegWrite_WB = 1'b1;
    bus.MemtoReg_WB = 1'b0;
    bus.rd_WB = 5'd0;
    bus.ALUResult_WB = 64'hDEAD;
    bus.rs2_ID = 5'd0;
    #1;
    vectors++;
    if (bus.wb_we !== 1'b0 || bus.wb_data !== 64'hDEAD) begin
      miscompares++;
      $display("FAIL x0_strobe: got we=%b data=%h expected we=0 data=dead", bus.wb_we, bus.wb_data);
    end
    vectors++;
    if (bus.rs2_data !== 64'd0) begin
      miscompares++;
      $display("FAIL x0_no_bypass: got %h expected 0", bus.rs2_data);
    end
    step();
    bus.RegWrite_WB = 1'b0;
    #1;
    vectors++;
    if (bus.rs2_data !== 64'd0) begin
      miscompares++;
      $display("FAIL x0_read: got %h expected 0", bus.rs2_data);
    end
    vectors++;
    if (bus.wb_count !== 32'd2) begin
      miscompares++;
      $display("FAIL x0_count: got %0d expected 2", bus.wb_count);
    end
  endtask

  task automatic test_hazard();
    bus.RegWrite_WB = 1'b1;
    bus.MemtoReg_WB = 1'b0;
    bus.rd_WB = 5'd7;
    bus.ALUResult_WB = 64'hA;
    step();
    bus.ALUResult_WB = 64'hB;
    bus.rs1_ID = 5'd7;
    bus.rs2_ID = 5'd5;
    #1;
    vectors++;
    if (bus.rs1_data !== (BYPASS ? 64'hB : 64'hA)) begin
      miscompares++;
      $display("FAIL hazard_same_cycle: got %h expected %h", bus.rs1_data, BYPASS ? 64'hB : 64'hA);
    end
    vectors++;
    if (bus.rs2_data !== 64'h2222) begin
      miscompares++;
      $display("FAIL hazard_other_port: got %h expected 2222", bus.rs2_data);
    end
    bus.rs2_ID = 5'd7;
    #1;
    vectors++;
    if (bus.rs2_data !== (BYPASS ? 64'hB : 64'hA)) begin
      miscompares++;
      $display("FAIL hazard_port2: got %h expected %h", bus.rs2_data, BYPASS ? 64'hB : 64'hA);
    end
    step();
    bus.RegWrite_WB = 1'b0;
    #1;
    vectors++;
    if (bus.rs1_data !== 64'hB || bus.rs2_data !== 64'hB) begin
      miscompares++;
      $display("FAIL hazard_after_edge: got %h/%h expected b/b", bus.rs1_data, bus.rs2_data);
    end
    vectors++;
    if (bus.wb_count !== 32'd4) begin
      miscompares++;
      $display("FAIL hazard_count: got %0d expected 4", bus.wb_count);
    end
  endtask

  task automatic test_async_reset();
    bus.RegWrite_WB = 1'b1;
    bus.MemtoReg_WB = 1'b1;
    bus.rd_WB = 5'd3;
    bus.mem_read_data_WB = 64'hFF;
    bus.rs1_ID = 5'd3;
    bus.rs2_ID = 5'd5;
    step();
    step();
    vectors++;
    if (bus.wb_count !== 32'd6) begin
      miscompares++;
      $display("FAIL async_pre_count: got %0d expected 6", bus.wb_count);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.rs1_data !== 64'd0 || bus.rs2_data !== 64'd0) begin
      miscompares++;
      $display("FAIL async_clear_read: got %h/%h expected 0/0", bus.rs1_data, bus.rs2_data);
    end
    vectors++;
    if (bus.wb_count !== 32'd0) begin
      miscompares++;
      $display("FAIL async_clear_count: got %0d expected 0", bus.wb_count);
    end
    vectors++;
    if (bus.wb_data !== 64'hFF || bus.wb_we !== 1'b1) begin
      miscompares++;
      $display("FAIL async_comb_outputs: got %h we=%b expected ff we=1", bus.wb_data, bus.wb_we);
    end
    step();
    vectors++;
    if (bus.rs1_data !== 64'd0 || bus.wb_count !== 32'd0) begin
      miscompares++;
      $display("FAIL async_held_write_lost: got %h cnt=%0d expected 0 cnt=0", bus.rs1_data, bus.wb_count);
    end
    bus.MemtoReg_WB = 1'b0;
    bus.ALUResult_WB = 64'h55;
    reset_n = 1'b1;
    step();
    bus.RegWrite_WB = 1'b0;
    #1;
    vectors++;
    if (bus.rs1_data !== 64'h55 || bus.wb_count !== 32'd1) begin
      miscompares++;
      $display("FAIL async_first_write: got %h cnt=%0d expected 55 cnt=1", bus.rs1_data, bus.wb_count);
    end
    vectors++;
    if (bus.rs2_data !== 64'd0) begin
      miscompares++;
      $display("FAIL async_x5_cleared: got %h expected 0", bus.rs2_data);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd0;
    bus_s.MemtoReg_WB = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus_s.RegWrite_WB = 1'b1;
      bus_s.rd_WB = 5'((i % 31) + 1);
      bus_s.ALUResult_WB = 64'(i);
      step();
      exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (bus_s.wb_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, bus_s.wb_count, exp_cnt);
      end
      bus_s.RegWrite_WB = (i % 2) == 0 ? 1'b0 : 1'b1;
      bus_s.rd_WB = 5'd0;
      step();
      vectors++;
      if (bus_s.wb_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL wrap_idle[%0d]: got %0d expected %0d", i, bus_s.wb_count, exp_cnt);
      end
    end
    vectors++;
    if (bus_s.wb_count !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_final: got %0d expected 1", bus_s.wb_count);
    end
  endtask

  initial begin
    bus.RegWrite_WB = 1'b0;
    bus.MemtoReg_WB = 1'b0;
    bus.ALUResult_WB = '0;
    bus.mem_read_data_WB = '0;
    bus.rd_WB = '0;
    bus.rs1_ID = '0;
    bus.rs2_ID = '0;
    bus_s.RegWrite_WB = 1'b0;
    bus_s.MemtoReg_WB = 1'b0;
    bus_s.ALUResult_WB = '0;
    bus_s.mem_read_data_WB = '0;
    bus_s.rd_WB = '0;
    bus_s.rs1_ID = '0;
    bus_s.rs2_ID = '0;
    test_reset();
    test_select();
    test_x0();
    test_hazard();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and integer register file for the 64-bit pipelined core. It consumes the MEM/WB pipeline register outputs and selects the write-back value, either the ALU result or the load data. It commits that value to a 32-entry register file and serves the two decode-stage read ports. It also keeps a committed-write counter for performance monitoring.

## Interface
- `XLEN`, 64, data width of registers, ALU result and load data.
- `CNT_W`, 32, width of the committed-write counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `RegWrite_WB`  in  1  write enable from MEM/WB register.
- `MemtoReg_WB`  in  1  1 = write load data, 0 = write ALU result.
- `ALUResult_WB`  in  XLEN  ALU result from MEM/WB register.
- `mem_read_data_WB`  in  XLEN  load data from MEM/WB register.
- `rd_WB`  in  5  destination register index.
- `rs1_ID`  in  5  read port 1 index (decode stage).
- `rs2_ID`  in  5  read port 2 index (decode stage).
- `rs1_data`  out  XLEN  read port 1 data, combinational.
- `rs2_data`  out  XLEN  read port 2 data, combinational.
- `wb_data`  out  XLEN  selected write-back value, combinational, for the forwarding unit.
- `wb_we`  out  1  effective write strobe: `RegWrite_WB && rd_WB != 0`.
- `wb_count`  out  CNT_W  number of committed register writes since reset.

## Operation
- The write-back mux is `wb_data = MemtoReg_WB ? mem_read_data_WB : ALUResult_WB`. It is purely combinational.
- Register file: x1..x31 are XLEN-bit flops. x0 has no storage and always reads 0.
- Write: on a rising `clk` with `wb_we` = 1, `regs[rd_WB] <= wb_data`.
- A write to x0 (`RegWrite_WB` = 1, `rd_WB` = 0) is discarded. It also does not count.
- Read: `rsN_data = (rsN_ID == 0) ? 0 : regs[rsN_ID]`. Both ports are independent, and identical indices are legal.
- Counter: `wb_count` increments by 1 on each rising edge with `wb_we` = 1.
  - It wraps modulo 2^CNT_W from all-ones to 0 with no saturation or flag.
- Reset (`reset_n` = 0, asynchronous, at any time including mid-write):
  - All x1..x31 clear to 0 and `wb_count` clears to 0 immediately.
  - Any write in the same cycle is lost.
  - While reset is held, `rs1_data` = `rs2_data` = 0 regardless of index (bypass included).
  - `wb_data` and `wb_we` remain combinational functions of the inputs.
- Reset release: the first write can commit on the first rising edge with `reset_n` = 1.

## Timing
- Write latency: 1 cycle. Data presented in cycle N is visible in `regs` after edge N→N+1.
- Read latency: 0 cycles, combinational from `rsN_ID`.
- Same-cycle write/read of the same nonzero register is governed by `REGFILE_BYPASS_EN` (see Configuration).
- `wb_count` updates on the same edge as the register write it counts.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: the file is write-through.
  - If `wb_we` = 1 and `rsN_ID == rd_WB` (nonzero), then `rsN_data = wb_data` in the same cycle.
  - The hazard unit needs no extra stall for a WB→ID dependency.
- Undefined:
  - `rsN_data` returns the pre-write stored value in that cycle.
  - The new value is visible from the next cycle.
  - The hazard unit must stall one extra cycle for a WB→ID dependency.
- x0 reads 0 in both builds. A bypass never applies when `rd_WB` = 0.

## Test plan
- Reset then read: hold `reset_n` = 0 for 2 cycles, release, sweep `rs1_ID`/`rs2_ID` over 0..31 -> all data 0, `wb_count` = 0.
- ALU vs load select: `RegWrite_WB`=1, `rd_WB`=5, `ALUResult_WB`=64'h1111, `mem_read_data_WB`=64'h2222.
  - With `MemtoReg_WB`=0, one edge, `rs1_ID`=5 -> 64'h1111.
  - Repeat with `MemtoReg_WB`=1 -> 64'h2222, and `wb_count` = 2.
- x0 protection: write 64'hDEAD to `rd_WB`=0 with `RegWrite_WB`=1 -> `rs2_ID`=0 reads 0, `wb_we`=0, `wb_count` unchanged.
- Same-cycle hazard: x7 holds 64'hA, write 64'hB to x7 while `rs1_ID`=7.
  - Before the edge, `rs1_data` = 64'hB with `REGFILE_BYPASS_EN`, or 64'hA without.
  - After the edge, 64'hB in both builds.
- Async reset mid-operation: write 64'hFF to x3 on consecutive cycles, then drop `reset_n` between edges.
  - `rs1_ID`=3 reads 0 immediately, without waiting for a clock edge.
  - `wb_count` = 0 immediately.
- Counter wrap: build with `CNT_W`=4 and perform 17 valid writes -> `wb_count` = 1. Interleave `RegWrite_WB`=0 cycles -> no increment.
